// File: rtl/signed_pow2_div_pkg.sv
// Shared types and constants for the iterative signed divide-by-2^S unit.
package signed_pow2_div_pkg;

  // Sequencer states: wait for an operand, shift once per cycle, present result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Default operand/result width.
  localparam int W_DEFAULT = 8;

endpackage

// File: rtl/arith_shift_right_by_1.sv
// Single-step arithmetic right shift: the sign bit is replicated into the
// MSB and the bit falling off the LSB is reported for the sticky tracker.
module arith_shift_right_by_1 #(
  parameter int W = 8
) (
  input  logic [W-1:0] in,
  output logic [W-1:0] out,
  output logic         shifted_out_bit
);

  // Replicate the sign bit and drop the LSB.
  always_comb begin
    out             = {in[W-1], in[W-1:1]};
    shifted_out_bit = in[0];
  end

endmodule

// File: rtl/signed_pow2_divider_seq.sv
// Iterative signed divide-by-2^S. One operand is accepted over a valid/ready
// handshake, shifted right arithmetically one bit per cycle for S cycles by a
// single shared 1-bit stage, then held on the down port until consumed.
//
// Optional build macro SIGNED_POW2_DIV_ROUND_TO_ZERO_EN: when defined, a
// negative quotient that lost any set bits is incremented on the final shift,
// so the result truncates toward zero (matches signed '/'). When undefined,
// the result is floor(a / 2^S), i.e. a >>> S. Latency is the same either way.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high; valid, once raised, is held with stable data until that edge.
// up_ready is high only in IDLE; down_valid is high only in DONE, so a new
// operand is never accepted in the same cycle a result is consumed.
module signed_pow2_divider_seq
  import signed_pow2_div_pkg::*;
#(
  parameter int W  = W_DEFAULT,
  parameter int SW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [W-1:0]  up_data,
  input  logic [SW-1:0] up_shift,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [W-1:0]  down_data
);

  localparam logic [SW-1:0] CNT_ONE = SW'(1);

  state_t        state;
  logic [W-1:0]  data_q;
  logic [SW-1:0] count;
  logic          sticky;

  logic [W-1:0]  shifted;
  logic          shifted_out_bit;
  logic          sticky_next;
  logic [W-1:0]  final_q;

  // The one shared shift stage, fed from the working register.
  arith_shift_right_by_1 #(
    .W (W)
  ) u_shift (
    .in              (data_q),
    .out             (shifted),
    .shifted_out_bit (shifted_out_bit)
  );

  // Sticky records whether any 1 has been shifted out so far.
  always_comb begin
    sticky_next = sticky | shifted_out_bit;
  end

`ifdef SIGNED_POW2_DIV_ROUND_TO_ZERO_EN
  // Final-shift value: nudge inexact negative quotients up toward zero.
  always_comb begin
    final_q = shifted;
    if (shifted[W-1] && sticky_next) begin
      final_q = shifted + {{(W-1){1'b0}}, 1'b1};
    end
  end
`else
  // Final-shift value: plain floor division, no correction.
  always_comb begin
    final_q = shifted;
  end
`endif

  // up_ready is decoded straight from the state so it drops the moment an
  // operand is taken.
  always_comb begin
    up_ready = (state == IDLE);
  end

  // Sequencer: accept, shift S times, hold the registered result until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      data_q     <= '0;
      count      <= '0;
      sticky     <= 1'b0;
      down_valid <= 1'b0;
      down_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (up_valid) begin
            data_q <= up_data;
            count  <= up_shift;
            sticky <= 1'b0;
            if (up_shift != '0) begin
              state <= SHIFT;
            end else begin
              // S = 0: the operand is already the quotient.
              state      <= DONE;
              down_valid <= 1'b1;
              down_data  <= up_data;
            end
          end
        end

        SHIFT: begin
          data_q <= shifted;
          sticky <= sticky_next;
          count  <= count - CNT_ONE;
          if (count == CNT_ONE) begin
            data_q     <= final_q;
            state      <= DONE;
            down_valid <= 1'b1;
            down_data  <= final_q;
          end
        end

        DONE: begin
          // Result stays put under backpressure; IDLE is always revisited.
          if (down_ready) begin
            down_valid <= 1'b0;
            state      <= IDLE;
          end
        end

        default: begin
          state      <= IDLE;
          down_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_pow2_divider_seq.sv
// Bench for signed_pow2_divider_seq (W=8): directed operands with
// hand-computed quotients, backpressure hold, and async reset mid-shift.
module tb_signed_pow2_divider_seq;

  localparam int W  = 8;
  localparam int SW = 3;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          up_valid = 1'b0;
  logic          up_ready;
  logic [W-1:0]  up_data = '0;
  logic [SW-1:0] up_shift = '0;
  logic          down_valid;
  logic          down_ready = 1'b1;
  logic [W-1:0]  down_data;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  signed_pow2_divider_seq #(.W(W), .SW(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_shift   (up_shift),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           due_q[$];
  int           checks   = 0;
  int           failures = 0;
  bit           in_result = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send(input logic [W-1:0] d, input logic [SW-1:0] s,
                      input logic [W-1:0] e, input bit push, output int hs_cyc);
    bit ok;
    ok = 1'b0;
    hs_cyc = -1;
    up_data  = d;
    up_shift = s;
    up_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (up_ready) begin
        ok = 1'b1;
        hs_cyc = cyc;
        if (push) begin
          exp_q.push_back(e);
          due_q.push_back(cyc + int'(s) + 1);
        end
        break;
      end
      @(negedge clk);
    end
    if (!ok) fail_now("send_timeout");
    @(negedge clk);
    up_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && !down_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) fail_now("drain_timeout");
  endtask

  // ---------------- monitor ----------------
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      in_result = 1'b0;
    end else if (down_valid) begin
      if (!in_result) begin
        in_result = 1'b1;
        if (due_q.size() == 0) fail_now("latency_unexpected_valid");
        else chk("latency_cycle", cyc, due_q.pop_front());
      end
      if (down_ready) begin
        in_result = 1'b0;
        if (exp_q.size() == 0) fail_now("unexpected_result");
        else chk("down_data", {24'd0, down_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation did not finish");
  end

  // ---------------- expected values depending on rounding build ----------------
`ifdef SIGNED_POW2_DIV_ROUND_TO_ZERO_EN
  localparam logic [W-1:0] EXP_B5_S3 = 8'hF7;  // -75/8 -> -9
  localparam logic [W-1:0] EXP_FF_S1 = 8'h00;  // -1/2  -> 0
  localparam logic [W-1:0] EXP_81_S2 = 8'hE1;  // -127/4 -> -31
`else
  localparam logic [W-1:0] EXP_B5_S3 = 8'hF6;  // floor(-9.375) = -10
  localparam logic [W-1:0] EXP_FF_S1 = 8'hFF;  // floor(-0.5)  = -1
  localparam logic [W-1:0] EXP_81_S2 = 8'hE0;  // floor(-31.75) = -32
`endif

  // ---------------- main sequence ----------------
  initial begin
    int hs;
    int c0;

    repeat (3) @(negedge clk);
    chk("reset_up_ready", up_ready, 1);
    chk("reset_down_valid", down_valid, 0);
    chk("reset_down_data", down_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed operands, issued back to back.
    send(8'h64, 3'd2, 8'h19, 1'b1, hs);
    send(8'hB5, 3'd3, EXP_B5_S3, 1'b1, hs);
    send(8'h80, 3'd0, 8'h80, 1'b1, hs);
    send(8'h80, 3'd7, 8'hFF, 1'b1, hs);
    send(8'hFF, 3'd1, EXP_FF_S1, 1'b1, hs);
    send(8'h7F, 3'd7, 8'h00, 1'b1, hs);
    send(8'h01, 3'd0, 8'h01, 1'b1, hs);
    send(8'h81, 3'd2, EXP_81_S2, 1'b1, hs);
    wait_drain();

    // Backpressure: result must hold, no new operand accepted.
    down_ready = 1'b0;
    send(8'h40, 3'd1, 8'h20, 1'b1, hs);
    up_data  = 8'h10;
    up_shift = 3'd0;
    up_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk("bp_up_ready", up_ready, 0);
      if (i >= 2) begin
        chk("bp_down_valid", down_valid, 1);
        chk("bp_down_data", down_data, 8'h20);
      end
      @(negedge clk);
    end
    down_ready = 1'b1;
    chk("bp_release_up_ready", up_ready, 0);
    c0 = cyc;
    send(8'h10, 3'd0, 8'h10, 1'b1, hs);
    chk("bp_accept_cycle", hs, c0 + 1);
    wait_drain();
    chk("hold_last_result", down_data, 8'h10);

    // Async reset in the middle of a shift sequence.
    send(8'h90, 3'd5, 8'h00, 1'b0, hs);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_up_ready", up_ready, 1);
    chk("rst_down_valid", down_valid, 0);
    chk("rst_down_data", down_data, 0);
    exp_q.delete();
    due_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("post_rst_no_valid", down_valid, 0);
      @(negedge clk);
    end
    send(8'h90, 3'd4, 8'hF9, 1'b1, hs);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
